// File: rtl/request_pkg.sv
//==============================================================================
// Module  : request_pkg
// Brief   : Shared types and helpers for the multi-channel request unit.
// Revision: 1.0
//==============================================================================
`default_nettype none

package request_pkg;

    localparam int MAX_CH = 8;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_e;

    // One-hot to binary index; callers zero-extend narrower vectors to MAX_CH.
    function automatic logic [IDX_W-1:0] oh2idx(input logic [MAX_CH-1:0] i_oh);
        logic [IDX_W-1:0] w_idx;
        w_idx = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i_oh[i]) w_idx = IDX_W'(i);
        end
        return w_idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick of one pending channel, searching
//           upward from the pointer and wrapping to channel 0.
// Revision: 1.0
//==============================================================================
`default_nettype none

module rr_arbiter
    import request_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]   i_pend,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NCH-1:0]   o_grant
);

    logic [NCH-1:0] w_mask;
    logic [NCH-1:0] w_hi;
    logic [NCH-1:0] w_src;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            w_mask[i] = (IDX_W'(i) >= i_ptr);
        end
    end

    // Prefer channels at or above the pointer; otherwise wrap to the bottom.
    assign w_hi    = i_pend & w_mask;
    assign w_src   = (|w_hi) ? w_hi : i_pend;
    assign o_grant = w_src & (~w_src + NCH'(1));

endmodule

`default_nettype wire

// File: rtl/multi_request_unit.sv
//==============================================================================
// Module  : multi_request_unit
// Brief   : Arbitrates per-channel data read/write requests onto a single
//           memory port; optional abort-on-timeout via REQ_TIMEOUT_EN.
// Revision: 1.0
//==============================================================================
`default_nettype none

module multi_request_unit
    import request_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int TMO_CYC = 255,
    parameter int CNT_W   = 8
) (
    input  logic           CLK,
    input  logic           nRST,
    input  logic [NCH-1:0] ren,
    input  logic [NCH-1:0] wen,
    input  logic           halt,
    input  logic           dhit,
    output logic           imemREN,
    output logic           dmemREN,
    output logic           dmemWEN,
    output logic [NCH-1:0] grant,
    output logic [NCH-1:0] done,
    output logic           busy,
    output logic           tmo_err
);

    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_tmo_last = CNT_W'(TMO_CYC - 1);

    state_e           r_state;
    logic [NCH-1:0]   r_pend;
    req_type_e        r_type [NCH];
    logic [NCH-1:0]   r_grant;
    logic [IDX_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dren;
    logic             r_dwen;
    logic             r_halt_pend;
    logic             r_tmo_err;

    logic             w_in_req;
    logic [NCH-1:0]   w_done;
    logic             w_tmo;
    logic             w_finish;
    logic             w_halt_now;
    logic [NCH-1:0]   w_arb_pend;
    logic [NCH-1:0]   w_arb_grant;
    logic             w_any;
    req_type_e        w_sel_type;
    logic [IDX_W-1:0] w_sel_idx;
    logic [IDX_W-1:0] w_nxt_ptr;
    logic             w_launch;
    logic [NCH-1:0]   w_req_new;
    logic [NCH-1:0]   w_clr;

    assign w_in_req   = (r_state == ST_REQ);
    assign w_done     = w_in_req ? (r_grant & {NCH{dhit}}) : '0;
    assign w_halt_now = halt | r_halt_pend;

`ifdef REQ_TIMEOUT_EN
    // Abort on the edge where the wait counter would reach TMO_CYC.
    assign w_tmo = w_in_req & ~dhit & (r_cnt == c_tmo_last);
`else
    assign w_tmo = 1'b0;
`endif

    assign w_finish = w_in_req & (dhit | w_tmo);
    assign w_clr    = w_finish ? r_grant : '0;

    // The current owner is masked so a completing request never re-wins.
    assign w_arb_pend = w_in_req ? (r_pend & ~r_grant) : r_pend;
    assign w_any      = |w_arb_pend;

    rr_arbiter #(
        .NCH (NCH)
    ) u_rr_arbiter (
        .i_pend  (w_arb_pend),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant)
    );

    always_comb begin
        w_sel_type = REQ_READ;
        for (int i = 0; i < NCH; i++) begin
            if (w_arb_grant[i]) w_sel_type = r_type[i];
        end
    end

    assign w_sel_idx = oh2idx(MAX_CH'(w_arb_grant));
    assign w_nxt_ptr = (w_sel_idx == IDX_W'(NCH - 1)) ? '0 : (w_sel_idx + IDX_W'(1));

    assign w_launch  = ~w_halt_now & w_any & ((r_state == ST_IDLE) | w_finish);
    assign w_req_new = (ren | wen) & ~r_pend & ~w_done & {NCH{r_state != ST_HALTED}};

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= ST_IDLE;
            r_pend      <= '0;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_dren      <= 1'b0;
            r_dwen      <= 1'b0;
            r_halt_pend <= 1'b0;
            r_tmo_err   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_type[i] <= REQ_READ;
            end
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_req_new;
            for (int i = 0; i < NCH; i++) begin
                if (w_req_new[i]) r_type[i] <= wen[i] ? REQ_WRITE : REQ_READ;
            end

            if (w_in_req && halt) r_halt_pend <= 1'b1;
            if (w_tmo)            r_tmo_err   <= 1'b1;

            if (w_launch) begin
                r_state <= ST_REQ;
                r_grant <= w_arb_grant;
                r_dren  <= (w_sel_type == REQ_READ);
                r_dwen  <= (w_sel_type == REQ_WRITE);
                r_ptr   <= w_nxt_ptr;
                r_cnt   <= '0;
            end else if (w_finish || ((r_state == ST_IDLE) && w_halt_now)) begin
                r_state <= w_halt_now ? ST_HALTED : ST_IDLE;
                r_grant <= '0;
                r_dren  <= 1'b0;
                r_dwen  <= 1'b0;
            end else if (w_in_req && (r_cnt != c_cnt_max)) begin
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign imemREN = (r_state != ST_HALTED);
    assign dmemREN = r_dren;
    assign dmemWEN = r_dwen;
    assign grant   = r_grant;
    // A reset cycle never reports completion.
    assign done    = w_done & {NCH{nRST}};
    assign busy    = w_in_req;
    assign tmo_err = r_tmo_err;

endmodule

`default_nettype wire

// File: tb/tb_multi_request_unit.sv
//==============================================================================
// Module  : tb_multi_request_unit
// Brief   : Directed tables plus randomized traffic against a transaction-level
//           model of multi_request_unit (honours REQ_TIMEOUT_EN).
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_multi_request_unit;

    localparam int NCH     = 3;
    localparam int TMO_CYC = 4;
`ifdef REQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           CLK = 1'b0;
    logic           nRST;
    logic [NCH-1:0] ren, wen;
    logic           halt, dhit;
    logic           imemREN, dmemREN, dmemWEN, busy, tmo_err;
    logic [NCH-1:0] grant, done;
    logic [10:0]    w_obs;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit           rstn;
        bit [NCH-1:0] ren;
        bit [NCH-1:0] wen;
        bit           halt;
        bit           dhit;
        bit [10:0]    exp;
    } step_t;

    multi_request_unit #(.NCH(NCH), .TMO_CYC(TMO_CYC), .CNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .halt(halt), .dhit(dhit),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .grant(grant), .done(done), .busy(busy), .tmo_err(tmo_err)
    );

    always #5 CLK = ~CLK;

    // Observed vector: {imemREN, dmemREN, dmemWEN, busy, tmo_err, grant, done}
    assign w_obs = {imemREN, dmemREN, dmemWEN, busy, tmo_err, grant, done};

    function automatic step_t st(bit r, bit [NCH-1:0] rq, bit [NCH-1:0] wq, bit h, bit d, bit [10:0] e);
        step_t s;
        s.rstn = r; s.ren = rq; s.wen = wq; s.halt = h; s.dhit = d; s.exp = e;
        return s;
    endfunction

    task automatic drive(input step_t s);
        nRST = s.rstn; ren = s.ren; wen = s.wen; halt = s.halt; dhit = s.dhit;
    endtask

    task automatic do_reset();
        drive(st(1'b0, '0, '0, 1'b0, 1'b0, '0));
        repeat (2) begin @(posedge CLK); #1; end
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        step_t q[$];
        q.push_back(st(1'b0, 3'b111, 3'b000, 1'b1, 1'b1, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b0, 3'b111, 3'b111, 1'b0, 1'b1, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        foreach (q[k]) begin
            drive(q[k]);
            @(negedge CLK);
            n_tests++;
            if (w_obs !== q[k].exp) begin
                n_fail++;
                $display("FAIL reset[%0d] got=%b expected=%b", k, w_obs, q[k].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_single_read();
        step_t q[$];
        do_reset();
        q.push_back(st(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_1_0_1_0_001_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_1_0_1_0_001_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 11'b1_1_0_1_0_001_001));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        foreach (q[k]) begin
            drive(q[k]);
            @(negedge CLK);
            n_tests++;
            if (w_obs !== q[k].exp) begin
                n_fail++;
                $display("FAIL single_read[%0d] got=%b expected=%b", k, w_obs, q[k].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t q[$];
        do_reset();
        q.push_back(st(1'b1, 3'b001, 3'b010, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_1_0_1_0_001_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 11'b1_1_0_1_0_001_001));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_1_1_0_010_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 11'b1_0_1_1_0_010_010));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        foreach (q[k]) begin
            drive(q[k]);
            @(negedge CLK);
            n_tests++;
            if (w_obs !== q[k].exp) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] got=%b expected=%b", k, w_obs, q[k].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_wen_priority();
        step_t q[$];
        do_reset();
        q.push_back(st(1'b1, 3'b010, 3'b010, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_1_1_0_010_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 11'b1_0_1_1_0_010_010));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        foreach (q[k]) begin
            drive(q[k]);
            @(negedge CLK);
            n_tests++;
            if (w_obs !== q[k].exp) begin
                n_fail++;
                $display("FAIL wen_priority[%0d] got=%b expected=%b", k, w_obs, q[k].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_halt();
        step_t q[$];
        do_reset();
        q.push_back(st(1'b1, 3'b000, 3'b100, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 11'b1_0_1_1_0_100_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_1_1_0_100_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 11'b1_0_1_1_0_100_100));
        q.push_back(st(1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 11'b0_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b111, 3'b011, 1'b0, 1'b1, 11'b0_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b0_0_0_0_0_000_000));
        foreach (q[k]) begin
            drive(q[k]);
            @(negedge CLK);
            n_tests++;
            if (w_obs !== q[k].exp) begin
                n_fail++;
                $display("FAIL halt_active[%0d] got=%b expected=%b", k, w_obs, q[k].exp);
            end
            @(posedge CLK); #1;
        end
        q.delete();
        do_reset();
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b1, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 11'b0_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b0_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b0_0_0_0_0_000_000));
        foreach (q[k]) begin
            drive(q[k]);
            @(negedge CLK);
            n_tests++;
            if (w_obs !== q[k].exp) begin
                n_fail++;
                $display("FAIL halt_idle[%0d] got=%b expected=%b", k, w_obs, q[k].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_timeout();
        step_t q[$];
        do_reset();
        q.push_back(st(1'b1, 3'b001, 3'b010, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
`ifdef REQ_TIMEOUT_EN
        repeat (TMO_CYC) q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_1_0_1_0_001_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_1_1_1_010_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 11'b1_0_1_1_1_010_010));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_1_000_000));
`else
        repeat (3 * TMO_CYC) q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_1_0_1_0_001_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 11'b1_1_0_1_0_001_001));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_1_1_0_010_000));
`endif
        foreach (q[k]) begin
            drive(q[k]);
            @(negedge CLK);
            n_tests++;
            if (w_obs !== q[k].exp) begin
                n_fail++;
                $display("FAIL timeout[%0d] got=%b expected=%b", k, w_obs, q[k].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid();
        step_t q[$];
        do_reset();
        q.push_back(st(1'b1, 3'b001, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_1_0_1_0_001_000));
        q.push_back(st(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 11'b1_1_0_1_0_001_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        q.push_back(st(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 11'b1_0_0_0_0_000_000));
        foreach (q[k]) begin
            drive(q[k]);
            @(negedge CLK);
            n_tests++;
            if (w_obs !== q[k].exp) begin
                n_fail++;
                $display("FAIL reset_mid[%0d] got=%b expected=%b", k, w_obs, q[k].exp);
            end
            @(posedge CLK); #1;
        end
    endtask

    // Transaction-level model: per-channel pending/type, one owner, a search start.
    task automatic test_random();
        int owner = -1, nxt = 0, held = 0, c;
        bit halted = 0, hreq = 0, err = 0, fin_d, fin_a, rstn, hl, dh;
        bit pend [NCH];
        bit wr   [NCH];
        bit cand [NCH];
        bit [NCH-1:0] rq, wq, g_oh, d_oh;
        bit [10:0] exp;
        do_reset();
        for (int i = 0; i < NCH; i++) begin pend[i] = 0; wr[i] = 0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            rstn = ($urandom_range(0, 49) != 0);
            for (int i = 0; i < NCH; i++) begin
                rq[i] = ($urandom_range(0, 3) == 0);
                wq[i] = ($urandom_range(0, 5) == 0);
            end
            hl = (cyc >= 520) && ($urandom_range(0, 15) == 0);
            dh = ($urandom_range(0, 2) == 0);
            nRST = rstn; ren = rq; wen = wq; halt = hl; dhit = dh;

            g_oh = '0;
            if (owner >= 0) g_oh[owner] = 1'b1;
            d_oh = (rstn && dh) ? g_oh : '0;
            exp  = {!halted, (owner >= 0) ? !wr[owner] : 1'b0, (owner >= 0) ? wr[owner] : 1'b0,
                    owner >= 0, err, g_oh, d_oh};
            @(negedge CLK);
            n_tests++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL random[cyc %0d] got=%b expected=%b", cyc, w_obs, exp);
            end

            if (!rstn) begin
                owner = -1; nxt = 0; held = 0; halted = 0; hreq = 0; err = 0;
                for (int i = 0; i < NCH; i++) begin pend[i] = 0; wr[i] = 0; end
            end else begin
                fin_d = (owner >= 0) && dh;
                fin_a = (owner >= 0) && !dh && TMO_EN && (held + 1 == TMO_CYC);
                for (int i = 0; i < NCH; i++) cand[i] = pend[i];
                if (fin_d || fin_a) cand[owner] = 0;
                for (int i = 0; i < NCH; i++) begin
                    if (!halted && (rq[i] || wq[i]) && !pend[i] && !(fin_d && owner == i)) begin
                        pend[i] = 1; wr[i] = wq[i];
                    end
                end
                if (fin_d || fin_a) pend[owner] = 0;
                if (!halted) begin
                    if (owner < 0 || fin_d || fin_a) begin
                        if (fin_a) err = 1;
                        owner = -1;
                        if (hl || hreq) begin
                            halted = 1;
                        end else begin
                            for (int k = 0; k < NCH; k++) begin
                                c = (nxt + k) % NCH;
                                if (owner < 0 && cand[c]) begin
                                    owner = c; nxt = (c + 1) % NCH; held = 0;
                                end
                            end
                        end
                    end else begin
                        held++;
                        if (hl) hreq = 1;
                    end
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        nRST = 1'b0; ren = '0; wen = '0; halt = 1'b0; dhit = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        test_reset();
        test_single_read();
        test_back_to_back();
        test_wen_priority();
        test_halt();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
